// File: rtl/lcd_hd44780_responder.sv
// Receiving end of an HD44780-style 4-bit LCD bus: power-on nibble sequence, byte pairing,
// command decode and a 2x16 display RAM. Define LCD_RESP_SYNC_EN to add a 2-flop input synchronizer.
module lcd_hd44780_responder #(
  parameter logic [7:0]  CLEAR_CHAR = 8'h20,
  parameter int unsigned POR_COUNT  = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLcdE,
  input  logic       iLcdRs,
  input  logic       iLcdRw,
  input  logic [3:0] iLcdData,
  input  logic [4:0] iRdAddr,
  output logic [7:0] oRdChar,
  output logic [7:0] oByte,
  output logic       oByteIsData,
  output logic       oByteValid,
  output logic [4:0] oCursor,
  output logic       oInitDone,
  output logic       oDisplayOn,
  output logic       oBusy,
  output logic       oProtoErr
);

  localparam int unsigned      POR_W   = (POR_COUNT < 2) ? 1 : $clog2(POR_COUNT + 1);
  localparam logic [POR_W-1:0] POR_MAX = POR_W'(POR_COUNT);

  typedef enum logic [1:0] {S_CLR = 2'd0, S_POR = 2'd1, S_HI = 2'd2, S_LO = 2'd3} state_t;

  logic       e_s, rs_s, rw_s, e_d, fall;
  logic [3:0] dat_s;

  // Input capture stage
`ifdef LCD_RESP_SYNC_EN
  logic [6:0] sync_p0, sync_p1;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {iLcdE, iLcdRs, iLcdRw, iLcdData};
      sync_p1 <= sync_p0;
    end
  end
  assign {e_s, rs_s, rw_s, dat_s} = sync_p1;
`else
  assign {e_s, rs_s, rw_s, dat_s} = {iLcdE, iLcdRs, iLcdRw, iLcdData};
`endif

  assign fall = e_d & ~e_s;

  state_t           state_q, state_n;
  logic [4:0]       clr_idx_q, clr_idx_n;
  logic             clr_to_hi_q, clr_to_hi_n;
  logic [POR_W-1:0] por_cnt_q, por_cnt_n;
  logic [3:0]       hi_q, hi_n;
  logic             hi_rs_q, hi_rs_n;
  logic [4:0]       cursor_q, cursor_n;
  logic             incr_q, incr_n;
  logic             init_q, init_n;
  logic             disp_q, disp_n;
  logic             err_q, err_n;
  logic [7:0]       byte_q, byte_n;
  logic             byte_rs_q, byte_rs_n;
  logic             vld_q, vld_n;
  logic [7:0]       rd_char_q;
  logic [7:0]       byte_w;
  logic             ram_we;
  logic [4:0]       ram_wa;
  logic [7:0]       ram_wd;
  logic [7:0]       ram [32];

  assign byte_w = {hi_q, dat_s};

  always_comb begin
    state_n     = state_q;
    clr_idx_n   = clr_idx_q;
    clr_to_hi_n = clr_to_hi_q;
    por_cnt_n   = por_cnt_q;
    hi_n        = hi_q;
    hi_rs_n     = hi_rs_q;
    cursor_n    = cursor_q;
    incr_n      = incr_q;
    init_n      = init_q;
    disp_n      = disp_q;
    err_n       = err_q;
    byte_n      = byte_q;
    byte_rs_n   = byte_rs_q;
    vld_n       = 1'b0;
    ram_we      = 1'b0;
    ram_wa      = cursor_q;
    ram_wd      = byte_w;
    if (state_q == S_CLR) begin
      ram_we    = 1'b1;
      ram_wa    = clr_idx_q;
      ram_wd    = CLEAR_CHAR;
      clr_idx_n = clr_idx_q + 5'd1;
      if (clr_idx_q == 5'd31) begin
        cursor_n = 5'd0;
        state_n  = clr_to_hi_q ? S_HI : S_POR;
      end
      if (fall) err_n = 1'b1;
    end else if (fall) begin
      if (rw_s) begin
        err_n = 1'b1;
      end else begin
        case (state_q)
          S_POR: begin
            if (!rs_s) begin
              if (dat_s == 4'h3) begin
                if (por_cnt_q != POR_MAX) por_cnt_n = por_cnt_q + POR_W'(1);
              end else if (dat_s == 4'h2 && por_cnt_q == POR_MAX) begin
                state_n = S_HI;
                init_n  = 1'b1;
              end else begin
                por_cnt_n = '0;
              end
            end
          end
          S_HI: begin
            hi_n    = dat_s;
            hi_rs_n = rs_s;
            state_n = S_LO;
          end
          S_LO: begin
            state_n   = S_HI;
            byte_n    = byte_w;
            byte_rs_n = rs_s;
            vld_n     = 1'b1;
            if (rs_s != hi_rs_q) err_n = 1'b1;
            if (rs_s) begin
              ram_we   = 1'b1;
              cursor_n = incr_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
            end else begin
              // Highest set bit selects the instruction
              casez (byte_w)
                8'b1???????: cursor_n = {byte_w[6], byte_w[3:0]};
                8'b00001???: disp_n = byte_w[2];
                8'b000001??: incr_n = byte_w[1];
                8'b0000001?: cursor_n = 5'd0;
                8'b00000001: begin
                  state_n     = S_CLR;
                  clr_idx_n   = 5'd0;
                  clr_to_hi_n = 1'b1;
                end
                default: begin end
              endcase
            end
          end
          default: begin end
        endcase
      end
    end
  end

  // Control and output register stage
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_CLR;
      clr_idx_q   <= 5'd0;
      clr_to_hi_q <= 1'b0;
      por_cnt_q   <= '0;
      hi_rs_q     <= 1'b0;
      cursor_q    <= 5'd0;
      incr_q      <= 1'b1;
      init_q      <= 1'b0;
      disp_q      <= 1'b0;
      err_q       <= 1'b0;
      byte_q      <= 8'd0;
      byte_rs_q   <= 1'b0;
      vld_q       <= 1'b0;
      e_d         <= 1'b0;
      rd_char_q   <= 8'd0;
    end else begin
      state_q     <= state_n;
      clr_idx_q   <= clr_idx_n;
      clr_to_hi_q <= clr_to_hi_n;
      por_cnt_q   <= por_cnt_n;
      hi_rs_q     <= hi_rs_n;
      cursor_q    <= cursor_n;
      incr_q      <= incr_n;
      init_q      <= init_n;
      disp_q      <= disp_n;
      err_q       <= err_n;
      byte_q      <= byte_n;
      byte_rs_q   <= byte_rs_n;
      vld_q       <= vld_n;
      e_d         <= e_s;
      rd_char_q   <= ram[iRdAddr];
    end
  end

  always_ff @(posedge Clock) begin
    hi_q <= hi_n;
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  assign oRdChar     = rd_char_q;
  assign oByte       = byte_q;
  assign oByteIsData = byte_rs_q;
  assign oByteValid  = vld_q;
  assign oCursor     = cursor_q;
  assign oInitDone   = init_q;
  assign oDisplayOn  = disp_q;
  assign oBusy       = (state_q == S_CLR);
  assign oProtoErr   = err_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Bench for lcd_hd44780_responder: directed vector table, corner-case sequences and
// randomized bytes checked against a behavioural LCD model.
module tb_lcd_hd44780_responder;
  logic       Clock = 1'b0, Reset = 1'b1;
  logic       iLcdE = 1'b0, iLcdRs = 1'b0, iLcdRw = 1'b0;
  logic [3:0] iLcdData = 4'h0;
  logic [4:0] iRdAddr = 5'd0;
  logic [7:0] oRdChar, oByte;
  logic       oByteIsData, oByteValid, oInitDone, oDisplayOn, oBusy, oProtoErr;
  logic [4:0] oCursor;

`ifdef LCD_RESP_SYNC_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  always #5 Clock = ~Clock;

  lcd_hd44780_responder dut (
    .Clock(Clock), .Reset(Reset), .iLcdE(iLcdE), .iLcdRs(iLcdRs), .iLcdRw(iLcdRw),
    .iLcdData(iLcdData), .iRdAddr(iRdAddr), .oRdChar(oRdChar), .oByte(oByte),
    .oByteIsData(oByteIsData), .oByteValid(oByteValid), .oCursor(oCursor),
    .oInitDone(oInitDone), .oDisplayOn(oDisplayOn), .oBusy(oBusy), .oProtoErr(oProtoErr)
  );

  int checks = 0, errors = 0, vld_cnt = 0, vld_base = 0;
  always @(negedge Clock) if (oByteValid === 1'b1) vld_cnt++;

  // Behavioural model of the display
  bit [7:0] m_ram [32];
  int       m_cur, m_por, m_nvalid;
  bit       m_incr, m_disp, m_init, m_err, m_busy, m_have_hi, m_hi_rs, m_byte_rs;
  bit [3:0] m_hi;
  bit [7:0] m_byte;

  typedef struct {
    bit         rs;
    logic [7:0] b;
    logic [4:0] cur;
    bit         disp;
  } vec_t;
  vec_t tv [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
    m_cur = 0; m_por = 0; m_nvalid = 0;
    m_incr = 1; m_disp = 0; m_init = 0; m_err = 0; m_busy = 1; m_have_hi = 0;
    m_hi_rs = 0; m_hi = 0; m_byte = 0; m_byte_rs = 0;
  endtask

  task automatic model_exec(input bit rs, input bit [7:0] b);
    if (rs) begin
      m_ram[m_cur] = b;
      m_cur = m_incr ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
    end else if (b >= 8'h80) m_cur = (b[6] ? 16 : 0) + int'(b % 16);
    else if (b >= 8'h10) begin end
    else if (b >= 8'h08) m_disp = b[2];
    else if (b >= 8'h04) m_incr = b[1];
    else if (b >= 8'h02) m_cur = 0;
    else if (b == 8'h01) begin
      for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
      m_cur = 0;
      m_busy = 1;
    end
  endtask

  task automatic model_nib(input bit rs, input bit rw, input bit [3:0] d);
    if (m_busy || rw) begin
      m_err = 1;
    end else if (!m_init) begin
      if (!rs) begin
        if (d == 4'h3) begin
          if (m_por < 3) m_por++;
        end else if (d == 4'h2 && m_por == 3) m_init = 1;
        else m_por = 0;
      end
    end else if (!m_have_hi) begin
      m_hi = d; m_hi_rs = rs; m_have_hi = 1;
    end else begin
      m_have_hi = 0;
      m_byte = {m_hi, d};
      m_byte_rs = rs;
      m_nvalid++;
      if (rs != m_hi_rs) m_err = 1;
      model_exec(rs, {m_hi, d});
    end
  endtask

  task automatic nib(input bit rs, input bit rw, input logic [3:0] d);
    model_nib(rs, rw, d);
    @(negedge Clock);
    iLcdRs = rs; iLcdRw = rw; iLcdData = d; iLcdE = 1'b1;
    repeat (4) @(negedge Clock);
    iLcdE = 1'b0;
    repeat (4) @(negedge Clock);
    iLcdRw = 1'b0;
  endtask

  task automatic wbyte(input bit rs, input logic [7:0] b);
    nib(rs, 1'b0, b[7:4]);
    nib(rs, 1'b0, b[3:0]);
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    @(negedge Clock);
    iRdAddr = a;
    @(posedge Clock);
    #1 v = oRdChar;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (oBusy === 1'b1 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    chk("clear_done", oBusy, 0);
    m_busy = 0;
  endtask

  task automatic check_state();
    chk("cursor", oCursor, m_cur);
    chk("display_on", oDisplayOn, m_disp);
    chk("init_done", oInitDone, m_init);
    chk("proto_err", oProtoErr, m_err);
    chk("byte", oByte, m_byte);
    chk("byte_is_data", oByteIsData, m_byte_rs);
    chk("valid_count", vld_cnt - vld_base, m_nvalid);
  endtask

  task automatic check_ram();
    logic [7:0] v;
    for (int a = 0; a < 32; a++) begin
      rd(a[4:0], v);
      chk($sformatf("ram[%0d]", a), v, m_ram[a]);
    end
  endtask

  task automatic do_reset(input bit wait_clear);
    int n;
    @(negedge Clock);
    Reset = 1'b1; iLcdE = 1'b0; iLcdRs = 1'b0; iLcdRw = 1'b0; iLcdData = 4'h0;
    repeat (2) @(negedge Clock);
    chk("rst_byte", oByte, 0);
    chk("rst_valid", oByteValid, 0);
    chk("rst_cursor", oCursor, 0);
    chk("rst_init", oInitDone, 0);
    chk("rst_disp", oDisplayOn, 0);
    chk("rst_err", oProtoErr, 0);
    chk("rst_busy", oBusy, 1);
    chk("rst_rdchar", oRdChar, 0);
    model_reset();
    vld_base = vld_cnt;
    Reset = 1'b0;
    if (wait_clear) begin
      n = 0;
      while (oBusy === 1'b1 && n < 100) begin
        n++;
        @(negedge Clock);
      end
      chk("busy_cycles", n, 32);
      m_busy = 0;
    end
  endtask

  initial begin : main
    logic [7:0] v, r, b;
    bit         rs;
    int         kind, lat;

    tv[0] = '{rs: 1'b0, b: 8'h28, cur: 5'd0, disp: 1'b0};
    tv[1] = '{rs: 1'b0, b: 8'h06, cur: 5'd0, disp: 1'b0};
    tv[2] = '{rs: 1'b0, b: 8'h0C, cur: 5'd0, disp: 1'b1};
    tv[3] = '{rs: 1'b1, b: 8'h48, cur: 5'd1, disp: 1'b1};
    tv[4] = '{rs: 1'b1, b: 8'h69, cur: 5'd2, disp: 1'b1};

    do_reset(1'b1);
    check_ram();
    check_state();

    // Power-on sequence: short run fails, saturating run with an ignored RS=1 strobe succeeds
    nib(0, 0, 4'h3); nib(0, 0, 4'h3); nib(0, 0, 4'h2);
    chk("por_332_init", oInitDone, 0);
    nib(0, 0, 4'h3); nib(0, 0, 4'h3); nib(1, 0, 4'h2); nib(0, 0, 4'h3); nib(0, 0, 4'h3);
    chk("por_pending_init", oInitDone, 0);
    nib(0, 0, 4'h2);
    chk("por_init", oInitDone, 1);
    check_state();

    for (int i = 0; i < 5; i++) begin
      wbyte(tv[i].rs, tv[i].b);
      chk($sformatf("tv%0d_cursor", i), oCursor, tv[i].cur);
      chk($sformatf("tv%0d_disp", i), oDisplayOn, tv[i].disp);
      chk($sformatf("tv%0d_valid", i), vld_cnt - vld_base, i + 1);
    end
    rd(5'd0, v); chk("ram0_H", v, 8'h48);
    rd(5'd1, v); chk("ram1_i", v, 8'h69);
    check_state();

    // Line 2 addressing and wrap from 31 to 0
    wbyte(0, 8'hC0);
    for (int i = 0; i < 17; i++) wbyte(1, 8'(8'h41 + i));
    chk("wrap_cursor", oCursor, 1);
    rd(5'd16, v); chk("ram16", v, 8'h41);
    rd(5'd31, v); chk("ram31", v, 8'h50);
    rd(5'd0, v);  chk("ram0_wrap", v, 8'h51);
    check_ram();

    // Decrement mode, then clear
    wbyte(0, 8'h04); wbyte(0, 8'h8F); wbyte(1, 8'h5A);
    rd(5'd15, v); chk("ram15_dec", v, 8'h5A);
    chk("dec_cursor", oCursor, 14);
    wbyte(0, 8'h01);
    chk("clear_busy", oBusy, 1);
    wait_idle();
    chk("clear_cursor", oCursor, 0);
    check_ram();
    check_state();

    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 9);
      r = 8'($urandom);
      rs = 1'b0;
      case (kind)
        0, 1, 2, 3, 4: begin rs = 1'b1; b = r; end
        5: b = 8'h80 | r;
        6: b = 8'h04 | (r & 8'h03);
        7: b = 8'h08 | (r & 8'h07);
        8: b = r[0] ? 8'h02 : (8'h10 | (r & 8'h6F));
        default: b = (r[1:0] == 2'b00) ? 8'h01 : 8'h00;
      endcase
      wbyte(rs, b);
      if (m_busy) wait_idle();
      check_state();
    end
    check_ram();

    // Byte-valid latency measured from the first edge that samples E low
    nib(1, 0, 4'h4);
    model_nib(1, 0, 4'h7);
    @(negedge Clock);
    iLcdRs = 1'b1; iLcdData = 4'h7; iLcdE = 1'b1;
    repeat (4) @(negedge Clock);
    iLcdE = 1'b0;
    lat = 0;
    do begin
      @(posedge Clock);
      #1 lat++;
    end while (oByteValid !== 1'b1 && lat < 10);
    chk("valid_latency", lat, EXP_LAT);
    repeat (4) @(negedge Clock);
    check_state();

    // Protocol errors: write-strobe with RW=1, sticky flag, strobe during clear, RS mismatch
    nib(0, 1, 4'h5);
    chk("rw_err", oProtoErr, 1);
    check_state();
    wbyte(1, 8'h33);
    check_state();
    nib(0, 0, 4'h4);
    do_reset(1'b0);
    nib(0, 0, 4'h3);
    wait_idle();
    chk("clr_strobe_err", oProtoErr, 1);
    check_state();
    do_reset(1'b1);
    nib(0, 0, 4'h3); nib(0, 0, 4'h3); nib(0, 0, 4'h3); nib(0, 0, 4'h2);
    nib(0, 0, 4'h4); nib(1, 0, 4'h1);
    chk("rs_mismatch_err", oProtoErr, 1);
    chk("rs_mismatch_byte", oByte, 8'h41);
    check_state();
    check_ram();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- Behavioural responder for the HD44780-style 4-bit LCD bus: the receiving end of the character-LCD driver (lcd_rs, lcd_rw, lcd_e, lcd_7..lcd_4).
- Detects enable falling edges, runs the power-on nibble sequence, pairs nibbles into bytes, and decodes the commands the driver issues.
- Holds a 32-character display RAM (2 lines x 16) readable by a side port.
- Used on-chip as a loopback checker and in simulation as the LCD model for driver regression.

Parameters:
- CLEAR_CHAR, 8'h20, value written to every RAM entry by clear and by reset.
- POR_COUNT, 3, number of 0x3 nibbles required before the 0x2 nibble that enters 4-bit mode.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- iLcdE  in  1  enable strobe; data is captured on its falling edge.
- iLcdRs  in  1  register select: 0 = command, 1 = data.
- iLcdRw  in  1  read/write; must be 0 (writes only).
- iLcdData  in  4  nibble, bit 3 = lcd_7.
- iRdAddr  in  5  RAM read index: 0-15 line 0, 16-31 line 1.
- oRdChar  out  8  RAM[iRdAddr]; registered, 1-cycle read latency.
- oByte  out  8  last assembled byte.
- oByteIsData  out  1  RS value of the last assembled byte.
- oByteValid  out  1  one-cycle pulse when oByte/oByteIsData update.
- oCursor  out  5  current RAM write index.
- oInitDone  out  1  high once 4-bit mode is entered.
- oDisplayOn  out  1  display-on bit D from the last display-control command.
- oBusy  out  1  high while clearing RAM.
- oProtoErr  out  1  sticky error flag; cleared only by Reset.

Behaviour:
- Reset values (synchronous, active-high): oByte=0, oByteIsData=0, oByteValid=0, oCursor=0, oInitDone=0, oDisplayOn=0, oProtoErr=0, increment mode=1, POR counter=0, state=S_CLR, oBusy=1, oRdChar=0.
- Reset applied mid-byte or mid-clear discards all partial state.
- Strobe detection:
  - e_d is the registered copy of e_s; fall = e_d & ~e_s.
  - {rs, rw, data} are captured together with e_s.
- FSM states: S_CLR, S_POR, S_HI, S_LO.
- S_CLR:
  - Writes CLEAR_CHAR to RAM[0..31], one entry per cycle (32 cycles), oBusy=1.
  - Then: cursor=0, oBusy=0.
  - Exits to S_POR after reset, or to S_HI after a clear command.
  - Any fall during S_CLR sets oProtoErr and is dropped.
- S_POR (single-nibble strobes, RS=0):
  - Nibble 0x3 increments the POR counter, saturating at POR_COUNT.
  - Nibble 0x2 with counter==POR_COUNT goes to S_HI and sets oInitDone=1.
  - Any other nibble clears the counter.
  - RS=1 strobes are ignored.
- S_HI: on a fall, latch the high nibble and RS, then go to S_LO.
- S_LO:
  - On a fall, form the byte {hi, lo}, go to S_HI, pulse oByteValid and execute the byte.
  - If RS differs from the high-nibble RS, set oProtoErr; the byte still executes using the low-nibble RS.
- Any fall with rw=1, in any state, sets oProtoErr and is ignored with no state change.
- Command decode (RS=0), by priority of the highest set bit:
  - 0x80|a: cursor = {a[6], a[3:0]}, so 0x80 gives 0 and 0xC0 gives 16.
  - 0x20-0x3F function set: no effect.
  - 0x08-0x0F: oDisplayOn = bit 2.
  - 0x04-0x07: increment mode = bit 1.
  - 0x02-0x03: cursor=0.
  - 0x01: enter S_CLR.
  - 0x00: no effect.
- Data (RS=1): RAM[cursor] = byte.
  - Cursor then +1 if increment mode, otherwise -1.
  - The 5-bit index wraps: 31 goes to 0, 0 goes to 31.
- Latency: oByteValid is asserted on the clock edge immediately after the fall is detected. The RAM write and cursor update land on the same edge.
- Simultaneous read and write of the same index: oRdChar returns the old value (read-before-write).

Optional Feature:
- Macro: LCD_RESP_SYNC_EN.
- Defined: e_s, rs, rw and data pass through a 2-flop synchronizer. oByteValid is asserted 3 Clock edges after the first edge that samples iLcdE low.
- Undefined: e_s and the other inputs are taken directly from the ports (same clock domain). oByteValid is asserted 1 edge after the first low sample.
- All other behaviour is identical.

Test Plan:
- Reset: hold Reset 1 cycle, then release -> oBusy=1 for 32 cycles; afterwards every iRdAddr 0-31 reads 0x20, oInitDone=0.
- POR sequence: nibbles 3,3,3,2 (RS=0) -> oInitDone=1 after the 4th fall. The sequence 3,3,2 instead leaves oInitDone=0.
- Data writes: after init, send 0x28, 0x06, 0x0C, then data 'H' 'i' -> RAM[0]=0x48, RAM[1]=0x69, oCursor=2, oDisplayOn=1, oByteValid pulses 5 times.
- Line 2 and wrap: send 0xC0, then 17 data bytes 0x41.. -> RAM[16..31]=0x41..0x50, RAM[0]=0x51, oCursor=1.
- Decrement and clear: send 0x04, 0x8F, then data 0x5A -> RAM[15]=0x5A, oCursor=14. Then send 0x01 -> oBusy for 32 cycles, all entries 0x20, oCursor=0.
- Errors: a strobe with iLcdRw=1, or a high nibble RS=0 paired with a low nibble RS=1 -> oProtoErr=1, held until Reset. With the macro defined and undefined, the measured oByteValid latency is 3 and 1 respectively.
